// File: rtl/func1_arb.sv
// func1_arb: two-requester round-robin front end for one shared
// sqrt(a + cbrt(b)) core.
//
// A requester raises req_i[n] with its operands held stable. When the block
// is idle it grants one requester (ack_o pulse), copies that requester's
// operands onto core_a_bo/core_b_bo and pulses core_start_o. It then waits
// for the core to go busy and come back idle, captures core_y_bi into
// res_bo and pulses done_o to the owner.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   req_i[1:0]                   per-requester request, held until ack_o[n]
//   a0_bi, b0_bi, a1_bi, b1_bi   requester operands (8 bits each)
//   ack_o[1:0]                   one-cycle grant pulse
//   done_o[1:0]                  one-cycle completion pulse to the owner
//   res_bo[4:0]                  result, held until the next done_o
//   err_o                        timeout flag, valid with done_o
//   busy_o                       high whenever the FSM is not idle
//   core_a_bo, core_b_bo         operands to the shared core, held per grant
//   core_start_o                 one-cycle start pulse to the core
//   core_busy_i, core_y_bi       core status and result
//
// Configuration
//   FUNC1_ARB_TIMEOUT_EN  when defined, a transaction still in flight after
//                         TIMEOUT_CYCLES cycles is aborted with err_o=1 and
//                         res_bo=0. When undefined there is no counter,
//                         err_o is tied low and the block waits indefinitely.

module func1_arb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [7:0] a0_bi,
  input  logic [7:0] b0_bi,
  input  logic [7:0] a1_bi,
  input  logic [7:0] b1_bi,
  output logic [1:0] ack_o,
  output logic [1:0] done_o,
  output logic [4:0] res_bo,
  output logic       err_o,
  output logic       busy_o,
  output logic [7:0] core_a_bo,
  output logic [7:0] core_b_bo,
  output logic       core_start_o,
  input  logic       core_busy_i,
  input  logic [4:0] core_y_bi
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("func1_arb: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state;
  logic   ptr;     // last grantee; reset to 1 so requester 0 wins first
  logic   owner;   // requester that owns the transaction in flight
  logic   winner;

  // Both requesting: the one not granted last wins. A lone requester wins
  // outright, which for req_i=01/10 is simply req_i[1].
  always_comb begin
    winner = (req_i == 2'b11) ? ~ptr : req_i[1];
  end

  assign busy_o = (state != IDLE);

`ifdef FUNC1_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          core_finished;

  assign tmo_hit       = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign core_finished = (state == WAIT_DONE) && !core_busy_i;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      ptr          <= 1'b1;
      owner        <= 1'b0;
      ack_o        <= 2'b00;
      done_o       <= 2'b00;
      res_bo       <= 5'd0;
      core_a_bo    <= 8'd0;
      core_b_bo    <= 8'd0;
      core_start_o <= 1'b0;
`ifdef FUNC1_ARB_TIMEOUT_EN
      err_o        <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      ack_o        <= 2'b00;
      done_o       <= 2'b00;
      core_start_o <= 1'b0;

      case (state)
        IDLE: begin
          if (|req_i) begin
            ack_o        <= winner ? 2'b10 : 2'b01;
            core_a_bo    <= winner ? a1_bi : a0_bi;
            core_b_bo    <= winner ? b1_bi : b0_bi;
            core_start_o <= 1'b1;
            owner        <= winner;
            ptr          <= winner;
            state        <= WAIT_BUSY;
`ifdef FUNC1_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        WAIT_BUSY: begin
          if (core_busy_i) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!core_busy_i) begin
            res_bo <= core_y_bi;
            done_o <= owner ? 2'b10 : 2'b01;
            state  <= IDLE;
`ifdef FUNC1_ARB_TIMEOUT_EN
            err_o  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase

`ifdef FUNC1_ARB_TIMEOUT_EN
      // A genuine completion in the same cycle as the deadline takes
      // precedence over the abort.
      if (state != IDLE) begin
        if (tmo_hit && !core_finished) begin
          res_bo <= 5'd0;
          err_o  <= 1'b1;
          done_o <= owner ? 2'b10 : 2'b01;
          state  <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
